// File: rtl/freq_meter_sched_if.sv
// freq_meter_sched_if: register-file / counter side signals of the frequency
// meter scheduler. The slave modport is the scheduler; the master modport is
// whatever drives it (register file plus shared counter).
interface freq_meter_sched_if #(
  parameter int CH_NUM   = 4,
  parameter int C_CNT_BW = 32,
  parameter int SW       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
);
  logic                         EN_I;
  logic [CH_NUM-1:0]            CH_MASK_I;
  logic [C_CNT_BW-1:0]          CNT_I;
  logic [SW-1:0]                SEL_O;
  logic                         GATE_O;
  logic [CH_NUM*C_CNT_BW-1:0]   RESULT_O;
  logic [CH_NUM-1:0]            VALID_O;
  logic [CH_NUM-1:0]            ZERO_O;
  logic                         UPD_O;
  logic [SW-1:0]                UPD_CH_O;
  logic                         ROUND_O;
  logic [CH_NUM-1:0]            CHG_O;
  logic                         BUSY_O;

  modport slave (
    input  EN_I, CH_MASK_I, CNT_I,
    output SEL_O, GATE_O, RESULT_O, VALID_O, ZERO_O, UPD_O, UPD_CH_O,
           ROUND_O, CHG_O, BUSY_O
  );

  modport master (
    output EN_I, CH_MASK_I, CNT_I,
    input  SEL_O, GATE_O, RESULT_O, VALID_O, ZERO_O, UPD_O, UPD_CH_O,
           ROUND_O, CHG_O, BUSY_O
  );
endinterface

// File: rtl/freq_meter_sched.sv
// freq_meter_sched: time-shares one gated frequency counter between CH_NUM
// clocks. Selects a channel on the mux, lets it settle, brackets an exact
// GATE_CYC window with two gate pulses, waits for the counter result to cross
// into this domain and stores it per channel, walking the mask round-robin.
// Build macro FREQ_SCHED_CHG_DET_EN adds per-channel change detection (CHG_O).
module freq_meter_sched #(
  parameter int CH_NUM     = 4,
  parameter int C_CNT_BW   = 32,
  parameter int GATE_CYC   = 100000000,
  parameter int GATE_PW    = 10,
  parameter int SETTLE_CYC = 16,
  parameter int WAIT_CYC   = 8,
  parameter int CHG_TOL    = 1000
) (
  input logic               SYS_CLK_I,
  input logic               SYS_RSTN_I,
  freq_meter_sched_if.slave bus
);
  localparam int SW  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int SW1 = SW + 1;
  localparam int CW  = $clog2(GATE_CYC) + 1;

  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0]  PW_LAST     = CW'(GATE_PW - 1);
  localparam logic [CW-1:0]  MEAS_LAST   = CW'(GATE_CYC - GATE_PW - 1);
  localparam logic [CW-1:0]  WAIT_LAST   = CW'(WAIT_CYC - 1);
  localparam logic [SW-1:0]  LAST_CH     = SW'(CH_NUM - 1);
  localparam logic [SW1-1:0] CH_NUM_W    = SW1'(CH_NUM);

  if (CH_NUM < 2 || CH_NUM > 16 || GATE_PW < 1 || GATE_CYC <= GATE_PW ||
      SETTLE_CYC < 1 || WAIT_CYC < 1 || CHG_TOL < 0 ||
      SETTLE_CYC >= (2 ** CW) || WAIT_CYC >= (2 ** CW)) begin : g_param_chk
    $error("freq_meter_sched: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_ARM, S_MEAS, S_LATCH, S_WAIT, S_CAPT
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       phase;
  logic [SW-1:0]       sel, ptr, sel_inc, start, off, pick_ch, top_ch;
  logic [CH_NUM-1:0]   rot;
  logic [SW1-1:0]      sum;
  logic                gate, capt, mask_any, run_ok;
  logic [C_CNT_BW-1:0] res [CH_NUM];
  logic [CH_NUM-1:0]   valid, zero;

  assign mask_any = |bus.CH_MASK_I;
  assign run_ok   = bus.EN_I && mask_any;
  assign capt     = (state == S_CAPT);
  assign sel_inc  = (sel == LAST_CH) ? '0 : sel + 1'b1;

  // Next channel: first mask bit at or after the round-robin start, wrapping.
  always_comb begin
    start = capt ? sel_inc : ptr;
    rot   = CH_NUM'({bus.CH_MASK_I, bus.CH_MASK_I} >> start);
    off   = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (rot[i]) off = SW'(i);
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= CH_NUM_W) sum = sum - CH_NUM_W;
    pick_ch = sum[SW-1:0];
  end

  // Highest enabled channel marks the end of a round.
  always_comb begin
    top_ch = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (bus.CH_MASK_I[i]) top_ch = SW'(i);
    end
  end

  // Next-state: each timed state leaves on its last phase count; EN low aborts.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run_ok) state_nxt = S_SETTLE;
      S_SETTLE: if (phase == SETTLE_LAST) state_nxt = S_ARM;
      S_ARM:    if (phase == PW_LAST) state_nxt = S_MEAS;
      S_MEAS:   if (phase == MEAS_LAST) state_nxt = S_LATCH;
      S_LATCH:  if (phase == PW_LAST) state_nxt = S_WAIT;
      S_WAIT:   if (phase == WAIT_LAST) state_nxt = S_CAPT;
      S_CAPT:   state_nxt = run_ok ? S_SETTLE : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (!bus.EN_I) state_nxt = S_IDLE;
  end

  // State, phase counter, mux select, round-robin pointer and registered gate.
  always_ff @(posedge SYS_CLK_I or negedge SYS_RSTN_I) begin
    if (!SYS_RSTN_I) begin
      state <= S_IDLE;
      phase <= '0;
      sel   <= '0;
      ptr   <= '0;
      gate  <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= (state_nxt != state || state == S_IDLE) ? '0 : phase + 1'b1;
      gate  <= (state_nxt == S_ARM) || (state_nxt == S_LATCH);
      if (state_nxt == S_SETTLE && state != S_SETTLE) sel <= pick_ch;
      if (capt) ptr <= sel_inc;
    end
  end

  // Per-channel result capture; the ARM pulse's own latched value is never read.
  always_ff @(posedge SYS_CLK_I or negedge SYS_RSTN_I) begin
    if (!SYS_RSTN_I) begin
      for (int i = 0; i < CH_NUM; i++) res[i] <= '0;
      valid <= '0;
      zero  <= '0;
    end else if (capt) begin
      res[sel]   <= bus.CNT_I;
      valid[sel] <= 1'b1;
      zero[sel]  <= (bus.CNT_I == '0);
    end
  end

`ifdef FREQ_SCHED_CHG_DET_EN
  localparam logic [C_CNT_BW-1:0] TOL_W = C_CNT_BW'(CHG_TOL);
  logic [CH_NUM-1:0]   chg;
  logic [C_CNT_BW-1:0] diff;

  // Unsigned distance between the new count and the stored one.
  always_comb begin
    diff = (bus.CNT_I >= res[sel]) ? bus.CNT_I - res[sel] : res[sel] - bus.CNT_I;
  end

  // Change flag refreshes only when its channel is captured again.
  always_ff @(posedge SYS_CLK_I or negedge SYS_RSTN_I) begin
    if (!SYS_RSTN_I) chg <= '0;
    else if (capt) chg[sel] <= valid[sel] && (diff > TOL_W);
  end

  assign bus.CHG_O = chg;
`else
  assign bus.CHG_O = '0;
`endif

  assign bus.SEL_O    = sel;
  assign bus.GATE_O   = gate;
  assign bus.VALID_O  = valid;
  assign bus.ZERO_O   = zero;
  assign bus.UPD_O    = capt;
  assign bus.UPD_CH_O = capt ? sel : '0;
  assign bus.ROUND_O  = capt && mask_any && (top_ch == sel);
  assign bus.BUSY_O   = (state != S_IDLE);

  for (genvar g = 0; g < CH_NUM; g++) begin : g_res
    assign bus.RESULT_O[g*C_CNT_BW +: C_CNT_BW] = res[g];
  end
endmodule

// File: tb/tb_freq_meter_sched.sv
// tb_freq_meter_sched: randomized scoreboard bench for freq_meter_sched.
// The stimulus predicts gate edges and captures from the scheduling rules and
// queues them; a negedge monitor compares whatever the DUT presents.
module tb_freq_meter_sched;
  localparam int CH_NUM = 4, C_CNT_BW = 32, GATE_CYC = 100, GATE_PW = 2;
  localparam int SETTLE_CYC = 4, WAIT_CYC = 8, CHG_TOL = 5;
  localparam int PERIOD = SETTLE_CYC + GATE_CYC + GATE_PW + WAIT_CYC + 1;
  localparam int ARM_OFS = SETTLE_CYC + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  freq_meter_sched_if #(.CH_NUM(CH_NUM), .C_CNT_BW(C_CNT_BW)) bus ();

  freq_meter_sched #(
    .CH_NUM(CH_NUM), .C_CNT_BW(C_CNT_BW), .GATE_CYC(GATE_CYC), .GATE_PW(GATE_PW),
    .SETTLE_CYC(SETTLE_CYC), .WAIT_CYC(WAIT_CYC), .CHG_TOL(CHG_TOL)
  ) dut (
    .SYS_CLK_I(clk),
    .SYS_RSTN_I(rst_n),
    .bus(bus)
  );

  // Counter model: the count seen depends on the selected channel.
  logic [31:0] cnt_val [CH_NUM];
  assign bus.CNT_I = cnt_val[bus.SEL_O];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int ch; logic [31:0] val; bit round;} cap_t;
  cap_t cap_q[$];
  int   gate_q[$];

  logic [31:0] exp_res [CH_NUM];
  logic [3:0]  exp_valid, exp_zero, exp_chg;
  int          ptr_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [3:0] m, input int p);
    for (int i = 0; i < CH_NUM; i++)
      if (m[2'((p + i) % CH_NUM)]) return (p + i) % CH_NUM;
    return -1;
  endfunction

  function automatic int top_bit(input logic [3:0] m);
    int t = -1;
    for (int i = 0; i < CH_NUM; i++) if (m[2'(i)]) t = i;
    return t;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < CH_NUM; i++) exp_res[2'(i)] = '0;
    exp_valid = '0; exp_zero = '0; exp_chg = '0; ptr_m = 0;
  endtask

  // One measurement starting at base b: ARM rise at b+5, LATCH at b+105,
  // capture at b+PERIOD. A partial one only shows its ARM pulse.
  task automatic push_meas(input int b, input int ch, input logic [3:0] m_capt, input bit full);
    cap_t e;
    logic [1:0] c2;
    logic [31:0] d;
    c2 = 2'(ch);
    gate_q.push_back(b + ARM_OFS);
    if (full) begin
      gate_q.push_back(b + ARM_OFS + GATE_CYC);
      e.cyc = b + PERIOD; e.ch = ch; e.val = cnt_val[c2];
      e.round = (top_bit(m_capt) == ch);
      cap_q.push_back(e);
      d = (e.val >= exp_res[c2]) ? e.val - exp_res[c2] : exp_res[c2] - e.val;
`ifdef FREQ_SCHED_CHG_DET_EN
      exp_chg[c2] = exp_valid[c2] && (d > 32'(CHG_TOL));
`else
      if (d == 32'hFFFF_FFFF) exp_chg[c2] = 1'b0;
`endif
      exp_res[c2] = e.val; exp_valid[c2] = 1'b1; exp_zero[c2] = (e.val == 0);
      ptr_m = (ch + 1) % CH_NUM;
    end
  endtask

  task automatic at_cyc(input int t);
    while (cyc < t) @(negedge clk);
    #2;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < CH_NUM; i++)
      chk({tag, "_result"}, 32'(bus.RESULT_O >> (i * C_CNT_BW)), exp_res[2'(i)]);
    chk({tag, "_valid"}, 32'(bus.VALID_O), 32'(exp_valid));
    chk({tag, "_zero"},  32'(bus.ZERO_O),  32'(exp_zero));
    chk({tag, "_chg"},   32'(bus.CHG_O),   32'(exp_chg));
    chk({tag, "_queues"}, 32'(cap_q.size() + gate_q.size()), 32'd0);
  endtask

  // n full measurements over a fixed mask, then EN dropped 30 cycles into MEAS.
  task automatic run(input string tag, input logic [3:0] m, input int n);
    int b;
    bus.CH_MASK_I = m; bus.EN_I = 1'b1; b = cyc;
    for (int k = 0; k < n; k++) push_meas(b + k * PERIOD, pick(m, ptr_m), m, 1'b1);
    push_meas(b + n * PERIOD, pick(m, ptr_m), m, 1'b0);
    at_cyc(b + n * PERIOD + ARM_OFS + GATE_PW + 30);
    bus.EN_I = 1'b0;
    at_cyc(cyc + 1);
    chk({tag, "_abort_busy"}, 32'(bus.BUSY_O), 32'd0);
    chk({tag, "_abort_gate"}, 32'(bus.GATE_O), 32'd0);
    at_cyc(cyc + 3);
    check_state(tag);
  endtask

  // Monitor: gate edges and captures checked against the queued predictions.
  bit gate_prev = 1'b0;
  int gate_len = 0;
  bit pend = 1'b0;
  int pend_ch = 0;
  logic [31:0] pend_val = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      gate_prev = 1'b0; gate_len = 0; pend = 1'b0;
    end else begin
      if (pend) begin
        chk("capt_result", 32'(bus.RESULT_O >> (pend_ch * C_CNT_BW)), pend_val);
        pend = 1'b0;
      end
      if (bus.GATE_O) begin
        if (!gate_prev) begin
          if (gate_q.size() == 0) chk("gate_rise_unexpected", 32'(bus.GATE_O), 32'd0);
          else chk("gate_rise_cyc", cyc, gate_q.pop_front());
        end
        gate_len++;
      end else if (gate_prev) begin
        chk("gate_width", gate_len, GATE_PW);
        gate_len = 0;
      end
      gate_prev = bus.GATE_O;
      if (bus.UPD_O) begin
        if (cap_q.size() == 0) chk("upd_unexpected", 32'(bus.UPD_O), 32'd0);
        else begin
          cap_t e;
          e = cap_q.pop_front();
          chk("upd_cyc", cyc, e.cyc);
          chk("upd_ch", 32'(bus.UPD_CH_O), e.ch);
          chk("upd_sel", 32'(bus.SEL_O), e.ch);
          chk("upd_round", 32'(bus.ROUND_O), 32'(e.round));
          pend = 1'b1; pend_ch = e.ch; pend_val = e.val;
        end
      end else if (bus.ROUND_O) begin
        chk("round_without_upd", 32'(bus.ROUND_O), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    bus.EN_I = 1'b0; bus.CH_MASK_I = '0;
    for (int i = 0; i < CH_NUM; i++) cnt_val[2'(i)] = 32'(50 + 10 * i);
    model_clear();
    rst_n = 1'b0;
    at_cyc(3);
    chk("rst_sel", 32'(bus.SEL_O), 0);
    chk("rst_gate", 32'(bus.GATE_O), 0);
    chk("rst_busy", 32'(bus.BUSY_O), 0);
    chk("rst_upd", 32'(bus.UPD_O), 0);
    chk("rst_round", 32'(bus.ROUND_O), 0);
    chk("rst_upd_ch", 32'(bus.UPD_CH_O), 0);
    check_state("rst");
    rst_n = 1'b1;
    at_cyc(cyc + 2);

    // Mask 1011 with counts 50+10*ch: channels 0,1,3,0.
    run("A", 4'b1011, 4);
    chk("A_res0", 32'(bus.RESULT_O >> 0), 50);
    chk("A_res1", 32'(bus.RESULT_O >> 32), 60);
    chk("A_res3", 32'(bus.RESULT_O >> 96), 80);
    chk("A_valid", 32'(bus.VALID_O), 32'b1011);

    // Channel 1 reports no clock.
    for (int i = 0; i < CH_NUM; i++) cnt_val[2'(i)] = $urandom_range(1, 2000);
    cnt_val[1] = 0;
    run("B", 4'b1011, 3);
    chk("B_zero", 32'(bus.ZERO_O), 32'b0010);
    chk("B_valid", 32'(bus.VALID_O), 32'b1011);

    // Reset asserted while LATCH holds the gate high.
    bus.CH_MASK_I = 4'b1111; bus.EN_I = 1'b1; b = cyc;
    gate_q.push_back(b + ARM_OFS);
    gate_q.push_back(b + ARM_OFS + GATE_CYC);
    at_cyc(b + ARM_OFS + GATE_CYC);
    chk("C_gate_pre", 32'(bus.GATE_O), 1);
    chk("C_sel_pre", 32'(bus.SEL_O), pick(4'b1111, ptr_m));
    rst_n = 1'b0;
    #1;
    chk("C_gate", 32'(bus.GATE_O), 0);
    chk("C_busy", 32'(bus.BUSY_O), 0);
    chk("C_sel", 32'(bus.SEL_O), 0);
    bus.EN_I = 1'b0;
    model_clear();
    check_state("C");
    at_cyc(cyc + 2);
    rst_n = 1'b1;
    at_cyc(cyc + 2);

    // Mask 0011 -> 0100 during ch0 MEAS, then 0 during ch2 MEAS.
    for (int i = 0; i < CH_NUM; i++) cnt_val[2'(i)] = $urandom_range(1, 2000);
    bus.CH_MASK_I = 4'b0011; bus.EN_I = 1'b1; b = cyc;
    push_meas(b, pick(4'b0011, ptr_m), 4'b0100, 1'b1);
    at_cyc(b + 2);
    chk("D_restart_sel", 32'(bus.SEL_O), 0);
    at_cyc(b + 50);
    bus.CH_MASK_I = 4'b0100;
    push_meas(b + PERIOD, pick(4'b0100, ptr_m), 4'b0000, 1'b1);
    at_cyc(b + PERIOD + 50);
    bus.CH_MASK_I = 4'b0000;
    at_cyc(b + 2 * PERIOD + 1);
    chk("D_idle_busy", 32'(bus.BUSY_O), 0);
    chk("D_sel", 32'(bus.SEL_O), 2);
    at_cyc(cyc + 20);
    chk("D_stay_idle", 32'(bus.BUSY_O), 0);
    bus.EN_I = 1'b0;
    check_state("D");

    // Change detection on ch0: 50, 54, 50, 60.
    cnt_val[0] = 50; run("E1", 4'b0001, 1);
    cnt_val[0] = 54; run("E2", 4'b0001, 1);
    chk("E2_chg0", 32'(bus.CHG_O[0]), 0);
    cnt_val[0] = 50; run("E3", 4'b0001, 1);
    cnt_val[0] = 60; run("E4", 4'b0001, 2);
`ifdef FREQ_SCHED_CHG_DET_EN
    chk("E4_chg0", 32'(bus.CHG_O[0]), 0);
    cnt_val[0] = 50; run("E5", 4'b0001, 1);
    chk("E5_chg0", 32'(bus.CHG_O[0]), 1);
`else
    chk("E4_chg_off", 32'(bus.CHG_O), 0);
`endif

    // Random masks, counts and run lengths.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < CH_NUM; i++)
        cnt_val[2'(i)] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(1, 2000);
      run("F", 4'($urandom_range(1, 15)), $urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/freq_meter_sched.md
Name: freq_meter_sched

Overview:
- Time-shares one gated frequency counter between CH_NUM candidate clocks.
- The counter clears and latches on a gate pulse, and its result is already resynchronised to SYS_CLK_I.
- This block drives the clock-mux select, generates the two gate pulses bounding an exact GATE_CYC window, waits for the result to cross domains, captures it per channel, and walks enabled channels round-robin.
- Sits in the SYS_CLK_I domain between the register file and the counter/mux.

Parameters:
- CH_NUM, 4: number of measured channels, 2..16.
- C_CNT_BW, 32: count/result width.
- GATE_CYC, 100000000: gate window in SYS_CLK_I cycles, rising edge to rising edge. Must be > GATE_PW.
- GATE_PW, 10: gate pulse width in cycles, >= 1.
- SETTLE_CYC, 16: cycles after a mux switch before the first gate pulse, >= 1.
- WAIT_CYC, 8: cycles after the second gate pulse before sampling CNT_I. Covers counter CDC latency; >= 1.
- CHG_TOL, 1000: change-detect tolerance (optional feature only).

Ports:
- SYS_CLK_I  in  1  system clock.
- SYS_RSTN_I  in  1  asynchronous active-low reset.
- EN_I  in  1  level; scheduler runs while high.
- CH_MASK_I  in  CH_NUM  channel enable mask; bit n = measure channel n.
- CNT_I  in  C_CNT_BW  latched count from the shared counter, SYS_CLK_I domain.
- SEL_O  out  SW  mux select, SW = max(1, clog2(CH_NUM)).
- GATE_O  out  1  gate pulse to the counter.
- RESULT_O  out  CH_NUM*C_CNT_BW  per-channel result; channel n at [n*C_CNT_BW +: C_CNT_BW].
- VALID_O  out  CH_NUM  sticky per-channel result-valid.
- ZERO_O  out  CH_NUM  per-channel last result == 0 (no clock present).
- UPD_O  out  1  one-cycle pulse, a result was captured.
- UPD_CH_O  out  SW  channel captured, valid with UPD_O.
- ROUND_O  out  1  one-cycle pulse, round over mask complete.
- CHG_O  out  CH_NUM  change flags (optional feature).
- BUSY_O  out  1  high in any state except IDLE.

Behaviour:
- Reset (async on SYS_RSTN_I low, synchronous release) puts all outputs at 0, SEL_O=0, state IDLE, round-robin pointer at 0.
- States: IDLE, SETTLE, ARM, MEAS, LATCH, WAIT, CAPT.
- IDLE -> SETTLE when EN_I=1 and CH_MASK_I != 0.
  - Channel chosen = first set mask bit at or above pointer, wrapping.
  - SEL_O registered on entry to SETTLE.
- SETTLE: SETTLE_CYC cycles, GATE_O=0.
- ARM: GATE_PW cycles, GATE_O=1. This pulse clears the counter; the latched value it produces is discarded.
- MEAS: GATE_CYC-GATE_PW cycles, GATE_O=0.
- LATCH: GATE_PW cycles, GATE_O=1. Its rising edge is exactly GATE_CYC cycles after ARM's rising edge.
- WAIT: WAIT_CYC cycles.
- CAPT: 1 cycle.
  - RESULT_O[ch] <= CNT_I; VALID_O[ch] <= 1; ZERO_O[ch] <= (CNT_I==0).
  - UPD_O=1 and UPD_CH_O=ch.
  - ROUND_O=1 if ch is the highest set bit of CH_MASK_I sampled this cycle.
  - Pointer <= ch+1, wrapping CH_NUM-1 -> 0.
  - Next state is SETTLE on the next masked channel, or IDLE if EN_I=0 or the mask is 0.
- Single-channel mask: the same channel repeats; SEL_O unchanged but SETTLE is still executed.
- Per-channel period = SETTLE_CYC + GATE_CYC + GATE_PW + WAIT_CYC + 1.
- CH_MASK_I change mid-measurement: the current channel completes and is captured even if its bit was cleared. The new mask applies at the CAPT selection.
- EN_I=0 in any non-IDLE state: next cycle IDLE, GATE_O=0, no capture. RESULT_O/VALID_O/ZERO_O hold.
- Reset mid-measurement: everything cleared, including VALID_O.
- GATE_O is registered and glitch-free. Phase counter width is clog2(GATE_CYC)+1 bits.

Optional Feature:
- FREQ_SCHED_CHG_DET_EN defined:
  - In CAPT, for a channel with VALID_O already 1, CHG_O[ch] <= (|CNT_I - RESULT_O[ch]| > CHG_TOL), computed unsigned with magnitude, no wrap.
  - First capture after reset sets CHG_O[ch]=0.
  - CHG_O bits are sticky until the next capture of that channel.
- Undefined: CHG_O tied to 0 and no comparator logic is built.

Test Plan:
- Bench parameters: CH_NUM=4, GATE_CYC=100, GATE_PW=2, SETTLE_CYC=4, WAIT_CYC=8. CNT_I driven by a model returning 50+10*SEL_O.
- Mask 4'b1011, EN=1 -> SEL_O sequence 0,1,3,0.
  - GATE_O rising edges 100 cycles apart within each channel.
  - UPD_O every 115 cycles.
  - RESULT_O = {80, x, 60, 50}, VALID_O = 4'b1011.
  - ROUND_O with UPD_CH_O=3.
- Model returns 0 for ch1 -> ZERO_O[1]=1, VALID_O[1]=1. Others 0.
- EN_I dropped 30 cycles into MEAS -> GATE_O=0 and BUSY_O=0 the next cycle. No UPD_O. RESULT_O unchanged.
- Mask changed 4'b0011 -> 4'b0100 during ch0 MEAS -> ch0 still captured, next SEL_O=2. Mask 0 -> stays IDLE, BUSY_O=0.
- SYS_RSTN_I pulsed low mid-LATCH -> asynchronous clear of GATE_O, RESULT_O, and VALID_O. Restart at ch0 after release.
- With FREQ_SCHED_CHG_DET_EN and CHG_TOL=5: ch0 results 50 then 54 -> CHG_O[0]=0; 50 then 60 -> CHG_O[0]=1. Without the macro, CHG_O stays 0.
